// File: rtl/rat_arf_superscalar.sv
`default_nettype none
// ============================================================================
// Module   : rat_arf_superscalar
// Brief    : Multi-slot rename table / architectural register file with
//            in-group dependency resolution, single commit port and flush.
//            Optional same-cycle commit bypass: RAT_COMMIT_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rat_arf_superscalar #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_IDX_WIDTH  = 4,
    parameter int NUM_REGS       = 32,
    localparam int RW            = $clog2(NUM_REGS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DISPATCH_WIDTH-1:0]               disp_valid,
    input  logic [DISPATCH_WIDTH-1:0]               disp_rd_we,
    input  logic [DISPATCH_WIDTH*RW-1:0]            disp_rd_addr,
    input  logic [DISPATCH_WIDTH*RW-1:0]            disp_rs1_addr,
    input  logic [DISPATCH_WIDTH*RW-1:0]            disp_rs2_addr,
    input  logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] disp_rob_idx,
    input  logic                                    commit_valid,
    input  logic [RW-1:0]                           commit_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0]                commit_rob_idx,
    input  logic [DATA_WIDTH-1:0]                   commit_data,
    input  logic                                    flush,
    output logic [DISPATCH_WIDTH-1:0]               rs1_rdy,
    output logic [DISPATCH_WIDTH-1:0]               rs2_rdy,
    output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] rs1_rob_idx,
    output logic [DISPATCH_WIDTH*ROB_IDX_WIDTH-1:0] rs2_rob_idx,
    output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]    rs1_data,
    output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]    rs2_data
);

    logic [DATA_WIDTH-1:0]    r_data  [NUM_REGS];
    logic [ROB_IDX_WIDTH-1:0] r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0]      r_ready;

    logic [DISPATCH_WIDTH-1:0] w_disp_wr;
    logic                      w_commit_en;
    logic                      w_commit_match;

    assign w_commit_en    = commit_valid && (commit_rd_addr != '0);
    assign w_commit_match = w_commit_en && (r_tag[commit_rd_addr] == commit_rob_idx);

    for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : g_disp
        assign w_disp_wr[s] = disp_valid[s] && disp_rd_we[s] &&
                              (disp_rd_addr[s*RW +: RW] != '0);
    end

    // Rename writes follow the commit ready-set so a same-cycle rename wins,
    // and ascending slot order lets the youngest slot own a shared rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_data[r]  <= '0;
                r_tag[r]   <= '0;
                r_ready[r] <= 1'b1;
            end
        end else begin
            if (w_commit_en) begin
                r_data[commit_rd_addr] <= commit_data;
            end
            if (flush) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_tag[r]   <= '0;
                    r_ready[r] <= 1'b1;
                end
            end else begin
                if (w_commit_match) begin
                    r_ready[commit_rd_addr] <= 1'b1;
                end
                for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                    if (w_disp_wr[s]) begin
                        r_ready[disp_rd_addr[s*RW +: RW]] <= 1'b0;
                        r_tag[disp_rd_addr[s*RW +: RW]]   <= disp_rob_idx[s*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < DISPATCH_WIDTH; j++) begin : g_slot
        for (genvar k = 0; k < 2; k++) begin : g_src
            logic [RW-1:0]            w_addr;
            logic                     w_rdy;
            logic [ROB_IDX_WIDTH-1:0] w_tag;
            logic [DATA_WIDTH-1:0]    w_data;

            if (k == 0) begin : g_sel1
                assign w_addr = disp_rs1_addr[j*RW +: RW];
            end else begin : g_sel2
                assign w_addr = disp_rs2_addr[j*RW +: RW];
            end

            // Older slots are scanned in ascending order so the youngest
            // matching producer is the one left standing.
            always_comb begin
                w_rdy  = r_ready[w_addr];
                w_tag  = r_tag[w_addr];
                w_data = r_data[w_addr];
                if (w_addr == '0) begin
                    w_rdy  = 1'b1;
                    w_tag  = '0;
                    w_data = '0;
                end
`ifdef RAT_COMMIT_BYPASS_EN
                else if (w_commit_match && (commit_rd_addr == w_addr)) begin
                    w_rdy  = 1'b1;
                    w_data = commit_data;
                end
`endif
                for (int i = 0; i < j; i++) begin
                    if (w_disp_wr[i] && (disp_rd_addr[i*RW +: RW] == w_addr)) begin
                        w_rdy = 1'b0;
                        w_tag = disp_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
                    end
                end
            end

            if (k == 0) begin : g_out1
                assign rs1_rdy[j]                                 = w_rdy;
                assign rs1_rob_idx[j*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = w_tag;
                assign rs1_data[j*DATA_WIDTH +: DATA_WIDTH]       = w_data;
            end else begin : g_out2
                assign rs2_rdy[j]                                 = w_rdy;
                assign rs2_rob_idx[j*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] = w_tag;
                assign rs2_data[j*DATA_WIDTH +: DATA_WIDTH]       = w_data;
            end
        end
    end

endmodule
`default_nettype wire
